// File: rtl/exec_stage_mc.sv
// Single-issue execute stage: one-cycle ALU ops plus an optional iterative shift-add MUL.
// Define EXEC_STAGE_MC_MUL_EN to build the multiplier; otherwise op 6 is reported as illegal.
module exec_stage_mc #(
  parameter int WIDTH = 16,
  parameter int REGW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  output logic             inReady,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [REGW-1:0]  writeReg,
  input  logic             regWrt,
  input  logic             flush,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] result,
  output logic [REGW-1:0]  writeRegOut,
  output logic             regWrtOut,
  output logic             err,
  output logic             busy
);

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_XOR   = 3'd3,
    OP_SLT   = 3'd4,
    OP_PASSB = 3'd5,
    OP_MUL   = 3'd6,
    OP_ILL   = 3'd7
  } op_t;

  logic             accept;
  logic             drain;
  logic             isMul;
  logic             mulDone;
  logic [WIDTH-1:0] aluRes;
  logic             aluErr;

  assign accept = inValid && inReady;
  assign drain  = outValid && outReady;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    aluRes = '0;
    aluErr = 1'b0;
    case (op_t'(op))
      OP_ADD:   aluRes = srcA + srcB;
      OP_SUB:   aluRes = srcA - srcB;
      OP_AND:   aluRes = srcA & srcB;
      OP_XOR:   aluRes = srcA ^ srcB;
      OP_SLT:   aluRes = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      OP_PASSB: aluRes = srcB;
`ifdef EXEC_STAGE_MC_MUL_EN
      OP_MUL:   aluRes = '0;  // result comes from the iterative unit instead
`endif
      default:  aluErr = 1'b1;
    endcase
  end

`ifdef EXEC_STAGE_MC_MUL_EN
  localparam int CNTW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t           state;
  state_t           nextState;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNTW-1:0]  cnt;
  logic [REGW-1:0]  mulReg;
  logic             mulWrt;

  assign isMul   = (op_t'(op) == OP_MUL);
  assign mulDone = (state == MUL) && (cnt == CNTW'(WIDTH));
  assign busy    = (state == MUL);
  assign inReady = (state == IDLE) && (!outValid || outReady) && !flush;

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept && isMul) nextState = MUL;
      MUL:     if (mulDone) nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (flush) nextState = IDLE;
  end

  // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  // Multiplicand shifts left and multiplier right; WIDTH iterations, then one completion cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      mulReg <= '0;
      mulWrt <= 1'b0;
    end else if (accept && isMul) begin
      mcand  <= srcA;
      mplier <= srcB;
      acc    <= '0;
      cnt    <= '0;
      mulReg <= writeReg;
      mulWrt <= regWrt;
    end else if (state == MUL && !mulDone && !flush) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end
`else
  assign isMul   = 1'b0;
  assign mulDone = 1'b0;
  assign busy    = 1'b0;
  assign inReady = (!outValid || outReady) && !flush;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outValid    <= 1'b0;
      result      <= '0;
      writeRegOut <= '0;
      regWrtOut   <= 1'b0;
      err         <= 1'b0;
    end else if (flush) begin
      outValid <= 1'b0;
      err      <= 1'b0;
    end else if (mulDone) begin
`ifdef EXEC_STAGE_MC_MUL_EN
      result      <= acc;
      writeRegOut <= mulReg;
      regWrtOut   <= mulWrt;
`endif
      err      <= 1'b0;
      outValid <= 1'b1;
    end else if (accept) begin
      if (isMul) begin
        // Any previous result drained on this edge; the slot stays empty until MUL completes.
        outValid <= 1'b0;
        err      <= 1'b0;
      end else begin
        result      <= aluRes;
        writeRegOut <= writeReg;
        regWrtOut   <= regWrt;
        err         <= aluErr;
        outValid    <= 1'b1;
      end
    end else if (drain) begin
      outValid <= 1'b0;
      err      <= 1'b0;
    end
  end

endmodule

// File: doc/exec_stage_mc.md
EXEC_STAGE_MC -- requirements
Module: exec_stage_mc

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits (legal values 8 to 64).
REQ-002 Parameter REGW, default 3, destination-register index width.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, asynchronous active-low reset; asserting it low clears all state immediately.
REQ-005 Port inValid, input, 1, upstream presents an operation.
REQ-006 Port inReady, output, 1, stage can accept; transfer occurs when inValid and inReady are both high on a clock edge.
REQ-007 Port op, input, 3: 0 ADD, 1 SUB (A-B), 2 AND, 3 XOR, 4 SLT (signed A<B gives 1), 5 PASSB, 6 MUL; 7 is illegal.
REQ-008 Ports srcA and srcB, inputs, WIDTH each, operands.
REQ-009 Ports writeReg (input, REGW) and regWrt (input, 1), destination tag, carried with the operation.
REQ-010 Port flush, input, 1, synchronous kill of all in-flight work.
REQ-011 Port outValid, output, 1, result register holds a valid result.
REQ-012 Port outReady, input, 1, downstream accepts the result when outValid and outReady are both high.
REQ-013 Ports result (output, WIDTH), writeRegOut (output, REGW) and regWrtOut (output, 1) are the registered payload.
REQ-014 Port err, output, 1, registered with the payload; high for an illegal op.
REQ-015 Port busy, output, 1, high while the FSM is in MUL.

Function
REQ-016 FSM states: IDLE, MUL; reset state IDLE.
REQ-017 inReady = (state==IDLE) and (outValid==0 or outReady==1) and flush==0.
REQ-018 Non-MUL transfer: the payload is loaded on that edge, and outValid is 1 the next cycle (latency 1).
REQ-019 ADD, SUB and MUL results wrap modulo 2^WIDTH; SLT uses signed two's-complement compare, free of overflow error.
REQ-020 MUL transfer: latch operands and tag, go to MUL, and clear an accumulator and a cycle counter.
REQ-021 MUL behaviour: shift-add one bit of srcB per cycle for exactly WIDTH cycles, keeping only the low WIDTH bits of the product.
REQ-022 MUL completion: after the last iteration, load the result, set outValid, and return to IDLE.
REQ-023 MUL latency: outValid rises WIDTH+1 cycles after the accept edge.
REQ-024 Output hold: with outValid=1 and outReady=0, all outputs hold stable.
REQ-025 Back-to-back: with outReady=1, a new op is accepted on the same edge the old result drains; one result per cycle.
REQ-026 Illegal op (7): result=0, err=1, outValid next cycle; err tracks the payload and clears when that payload drains.
REQ-027 flush=1 on an edge: outValid is cleared, the FSM goes to IDLE with the MUL aborted, and no transfer occurs that cycle.
REQ-028 When flush and outReady are both high, flush wins.
REQ-029 inValid arriving while in MUL is not accepted; inReady stays 0 until the FSM returns to IDLE and the output slot is free.
REQ-030 busy is high exactly while state==MUL.

Reset
REQ-031 While rst=0: state=IDLE, outValid=0, result=0, writeRegOut=0, regWrtOut=0, err=0, busy=0, accumulator and counter=0.
REQ-032 Reset taking effect mid-MUL discards the operation; no result is produced after release.
REQ-033 inReady is 1 in the first cycle after reset release.

Configuration
REQ-034 Macro EXEC_STAGE_MC_MUL_EN: when defined, op 6 executes per REQ-020 to REQ-023.
REQ-035 When EXEC_STAGE_MC_MUL_EN is undefined: no MUL state or multiplier logic exists, op 6 is treated as illegal per REQ-026, and busy is tied to 0.

Verification
REQ-036 WIDTH=16: ADD 0xFFFF+0x0002 -> result 0x0001, outValid one cycle after accept, err=0.
REQ-037 SLT with A=0x8000, B=0x0001 -> result 0x0001; and SUB 0x0000-0x0001 -> 0xFFFF.
REQ-038 MUL_EN defined: MUL 0x0123*0x0010 -> 0x1230 with outValid exactly 17 cycles after accept; inReady=0 and busy=1 throughout MUL; with the macro undefined, the same stimulus -> result 0, err=1, latency 1.
REQ-039 Backpressure: hold outReady=0 for 5 cycles after an ADD -> result stable, inReady=0; raise outReady alongside a queued XOR 0x00FF^0x0F0F -> next result 0x0FF0 in the following cycle.
REQ-040 Flush at cycle 8 of a MUL -> busy=0 and outValid=0 next cycle; a subsequent PASSB 0x00AA -> result 0x00AA.
REQ-041 Drive rst low mid-MUL, then release -> all outputs 0, inReady=1 after release, and no stale outValid ever appears.
